// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, defaults and helpers for the clock-enable generator
package clk_div_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int lock_cnt_width(input int lock_cycles);
        return clog2(lock_cycles + 1);
    endfunction

    localparam int ACC_W_DEF       = 16;
    localparam int LOCK_CYCLES_DEF = 16;
    localparam int LOCK_CNT_W_DEF  = lock_cnt_width(LOCK_CYCLES_DEF);

    typedef enum logic {
        ST_COUNT  = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/phase_acc_ch.sv
// rtl/phase_acc_ch.sv - one fractional phase-accumulator channel with gated carry strobe
module phase_acc_ch #(
    parameter int ACC_W = 16,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic             gate,
    output logic             en,
    output logic             sq
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // A load restarts the phase from zero so the new rate begins cleanly next edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc <= '0;
            inc <= INC_RST;
            en  <= 1'b0;
            sq  <= 1'b0;
        end else if (load) begin
            acc <= '0;
            inc <= load_inc;
            en  <= 1'b0;
            sq  <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            en  <= sum[ACC_W] & gate;
            sq  <= sum[ACC_W-1];
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel runtime-programmable clock-enable generator with lock flag
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {16'h3D71, 16'h4000},
    localparam int CH_W = (NUM_CH > 2) ? clog2(NUM_CH) : 1
) (
    input  logic              CLKFPGA,
    input  logic              RST,
    input  logic              CFG_WE,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [ACC_W-1:0]  CFG_INC,
    output logic              CFG_ACK,
    output logic [NUM_CH-1:0] CLK_EN,
    output logic [NUM_CH-1:0] CLK_SQ,
    output logic              LOCKED
);

    localparam int LOCK_CNT_W = lock_cnt_width(LOCK_CYCLES);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    lock_state_t           state, state_nxt;
    logic [LOCK_CNT_W-1:0] cnt, cnt_nxt;
    logic                  locked_nxt;
    logic                  wr_ok;

    assign wr_ok = CFG_WE && ({1'b0, CFG_CH} < NUM_CH_V);

    always_ff @(posedge CLKFPGA) begin
        if (!RST) begin
            state   <= ST_COUNT;
            cnt     <= '0;
            LOCKED  <= 1'b0;
            CFG_ACK <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            LOCKED  <= locked_nxt;
            CFG_ACK <= wr_ok;
        end
    end

    // Any accepted write restarts the settle window, regardless of current state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (wr_ok) begin
            state_nxt = ST_COUNT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_COUNT: begin
                    if (cnt == LOCK_LAST) begin
                        state_nxt = ST_LOCKED;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_LOCKED: state_nxt = ST_LOCKED;
                default:   state_nxt = ST_COUNT;
            endcase
        end
        locked_nxt = (state_nxt == ST_LOCKED);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        phase_acc_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[g*ACC_W +: ACC_W])
        ) u_ch (
            .clk      (CLKFPGA),
            .resetn   (RST),
            .load     (wr_ok && (CFG_CH == CH_W'(g))),
            .load_inc (CFG_INC),
            .gate     (locked_nxt),
            .en       (CLK_EN[g]),
            .sq       (CLK_SQ[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi with a rate/lock reference model
module tb_clk_div_multi;

    localparam int LC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] inc;
    logic        ack;
    logic [2:0]  en;
    logic [2:0]  sq;
    logic        locked;

    int total = 0;
    int bad = 0;

    int       m_acc [3];
    int       m_inc [3];
    int       m_since;
    logic [2:0] m_en, m_sq;
    logic     m_ack, m_locked;

    clk_div_multi #(
        .NUM_CH      (3),
        .ACC_W       (16),
        .LOCK_CYCLES (LC),
        .INC_INIT    (48'h2000_3D71_4000)
    ) dut (
        .CLKFPGA (clk),
        .RST     (rst),
        .CFG_WE  (we),
        .CFG_CH  (ch),
        .CFG_INC (inc),
        .CFG_ACK (ack),
        .CLK_EN  (en),
        .CLK_SQ  (sq),
        .LOCKED  (locked)
    );

    always #5 clk = ~clk;

    function automatic int init_inc(input int i);
        case (i)
            0:       return 32'h4000;
            1:       return 32'h3D71;
            default: return 32'h2000;
        endcase
    endfunction

    task automatic tick();
        int s;
        bit wr;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = 0;
                m_inc[i] = init_inc(i);
            end
            m_since = 0; m_en = '0; m_sq = '0; m_ack = 1'b0; m_locked = 1'b0;
        end else begin
            wr = we && (int'(ch) < 3);
            if (wr) m_since = 0;
            else if (m_since < LC) m_since++;
            m_locked = (m_since >= LC);
            for (int i = 0; i < 3; i++) begin
                if (wr && int'(ch) == i) begin
                    m_acc[i] = 0; m_inc[i] = int'(inc); m_en[i] = 1'b0; m_sq[i] = 1'b0;
                end else begin
                    s = m_acc[i] + m_inc[i];
                    m_en[i] = (s >= 65536) && m_locked;
                    m_acc[i] = s % 65536;
                    m_sq[i] = (m_acc[i] >= 32768);
                end
            end
            m_ack = wr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int c, input logic [15:0] v);
        we = 1'b1; ch = 2'(c); inc = v;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        int lock_at = -1; int bad_en = 0; int bad_sq = 0; int bad_per = 0; int last = -1; int npul = 0;
        rst = 1'b0; we = 1'b0; ch = '0; inc = '0;
        repeat (3) tick();
        total++;
        if ({ack, locked, en, sq} !== 8'h00) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", {ack, locked, en, sq}, 8'h00);
        end
        rst = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (locked === 1'b1 && lock_at < 0) lock_at = k;
            if (lock_at < 0 && en !== 3'b000) bad_en++;
            if (sq[0] !== ((k % 4) >= 2)) bad_sq++;
            if (lock_at > 0 && en[0] === 1'b1) begin
                if (last >= 0 && k - last != 4) bad_per++;
                last = k; npul++;
            end
        end
        total++; if (lock_at != 16) begin bad++; $display("FAIL reset_lock_time got=%0d want=16", lock_at); end
        total++; if (bad_en != 0) begin bad++; $display("FAIL reset_en_gated got=%0d want=0", bad_en); end
        total++; if (bad_sq != 0) begin bad++; $display("FAIL reset_sq0_toggle got=%0d want=0", bad_sq); end
        total++; if (bad_per != 0 || npul != 12) begin
            bad++; $display("FAIL reset_en0_period got=%0d/%0d want=0/12", bad_per, npul);
        end
    endtask

    task automatic test_rate();
        int n = 0; int bad_alt = 0; int n1 = 0; int bad_m = 0;
        logic pe, ps;
        cfg_write(0, 16'h8000);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rate_ack got=%b want=1", ack); end
        while (locked !== 1'b1 && n < 40) begin tick(); n++; end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL rate_lock_timeout got=%b want=1", locked); end
        pe = en[0]; ps = sq[0];
        for (int k = 0; k < 20; k++) begin
            tick();
            if (en[0] === pe || sq[0] === ps) bad_alt++;
            pe = en[0]; ps = sq[0];
        end
        total++; if (bad_alt != 0) begin bad++; $display("FAIL rate_ch0_alternate got=%0d want=0", bad_alt); end
        for (int k = 0; k < 65536; k++) begin
            tick();
            if (en[1] === 1'b1) n1++;
            if (en !== m_en || sq !== m_sq) bad_m++;
        end
        total++; if (n1 != 15729) begin bad++; $display("FAIL rate_ch1_count got=%0d want=15729", n1); end
        total++; if (bad_m != 0) begin bad++; $display("FAIL rate_model got=%0d want=0", bad_m); end
    endtask

    task automatic test_reconfig();
        int acks = 0; int lock_k = -1; int bad_gate = 0; int bad_int = 0; int last = -1; int np = 0; int bad0 = 0;
        cfg_write(1, 16'h1000);
        total++;
        if (ack !== 1'b1 || locked !== 1'b0 || en !== 3'b000) begin
            bad++; $display("FAIL reconf_write_edge got=%b%b%b want=100", ack, locked, en);
        end
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (ack === 1'b1) acks++;
            if (locked === 1'b1 && lock_k < 0) lock_k = k;
            if (lock_k < 0 && en !== 3'b000) bad_gate++;
            if (lock_k > 0 && en[1] === 1'b1) begin
                if (last >= 0 && k - last != 16) bad_int++;
                last = k; np++;
            end
            if (lock_k > 0 && en[0] !== m_en[0]) bad0++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL reconf_extra_ack got=%0d want=0", acks); end
        total++; if (lock_k != 16) begin bad++; $display("FAIL reconf_relock got=%0d want=16", lock_k); end
        total++; if (bad_gate != 0) begin bad++; $display("FAIL reconf_gate got=%0d want=0", bad_gate); end
        total++; if (bad_int != 0 || np != 5) begin
            bad++; $display("FAIL reconf_ch1_period got=%0d/%0d want=0/5", bad_int, np);
        end
        total++; if (bad0 != 0) begin bad++; $display("FAIL reconf_ch0_resume got=%0d want=0", bad0); end
    endtask

    task automatic test_invalid_zero();
        int bad_m = 0; int bad_z = 0;
        cfg_write(3, 16'h1234);
        total++;
        if (ack !== 1'b0 || locked !== 1'b1 || en !== m_en || sq !== m_sq) begin
            bad++; $display("FAIL invalid_write got=%b%b%b%b want=01%b%b", ack, locked, en, sq, m_en, m_sq);
        end
        for (int k = 0; k < 32; k++) begin
            tick();
            if (locked !== 1'b1 || en !== m_en || sq !== m_sq) bad_m++;
        end
        total++; if (bad_m != 0) begin bad++; $display("FAIL invalid_no_effect got=%0d want=0", bad_m); end
        cfg_write(0, 16'h0000);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL zero_ack got=%b want=1", ack); end
        for (int k = 0; k < 100; k++) begin
            tick();
            if (en[0] !== 1'b0 || sq[0] !== 1'b0) bad_z++;
        end
        total++; if (bad_z != 0) begin bad++; $display("FAIL zero_ch0_stopped got=%0d want=0", bad_z); end
    endtask

    task automatic test_back_to_back();
        int acks = 0; int lock_k = -1; int last = -1; int bad_int = 0; int np = 0;
        cfg_write(0, 16'h2000); if (ack === 1'b1) acks++;
        cfg_write(0, 16'h4000); if (ack === 1'b1) acks++;
        cfg_write(1, 16'h8000); if (ack === 1'b1) acks++;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (ack === 1'b1) acks++;
            if (locked === 1'b1 && lock_k < 0) lock_k = k;
            if (lock_k > 0 && en[0] === 1'b1) begin
                if (last >= 0 && k - last != 4) bad_int++;
                last = k; np++;
            end
        end
        total++; if (acks != 3) begin bad++; $display("FAIL b2b_acks got=%0d want=3", acks); end
        total++; if (lock_k != 16) begin bad++; $display("FAIL b2b_lock got=%0d want=16", lock_k); end
        total++; if (bad_int != 0 || np < 10) begin
            bad++; $display("FAIL b2b_ch0_last_wins got=%0d/%0d want=0/>=10", bad_int, np);
        end
    endtask

    task automatic test_reset_mid();
        int lock_k = -1; int last = -1; int bad_int = 0; int np = 0; int bad_m = 0;
        cfg_write(0, 16'h0100);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({ack, locked, en, sq} !== 8'h00) begin
            bad++; $display("FAIL midreset_outputs got=%h want=%h", {ack, locked, en, sq}, 8'h00);
        end
        rst = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (locked === 1'b1 && lock_k < 0) lock_k = k;
            if (lock_k > 0 && en[0] === 1'b1) begin
                if (last >= 0 && k - last != 4) bad_int++;
                last = k; np++;
            end
            if (en !== m_en || sq !== m_sq) bad_m++;
        end
        total++; if (lock_k != 16) begin bad++; $display("FAIL midreset_lock got=%0d want=16", lock_k); end
        total++; if (bad_int != 0 || np != 12) begin
            bad++; $display("FAIL midreset_inc_init got=%0d/%0d want=0/12", bad_int, np);
        end
        total++; if (bad_m != 0) begin bad++; $display("FAIL midreset_model got=%0d want=0", bad_m); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            we  = ($urandom_range(0, 39) == 0);
            ch  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       inc = 16'($urandom_range(0, 3));
                1:       inc = 16'($urandom_range(32768, 65535));
                default: inc = 16'($urandom);
            endcase
            tick();
            total++;
            if ({ack, locked, en, sq} !== {m_ack, m_locked, m_en, m_sq}) begin
                bad++;
                if (bad < 20) $display("FAIL random_cycle%0d got=%b want=%b", n,
                                       {ack, locked, en, sq}, {m_ack, m_locked, m_en, m_sq});
            end
        end
        rst = 1'b1; we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rate();
        test_reconfig();
        test_invalid_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
